// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and widths for the instruction fetch unit.
package fetch_pkg;
  localparam int ADDR_W = 64;
  localparam int INSTR_W = 32;
  localparam logic [1:0] PC_ALIGN_MASK = 2'b11;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, FAULT} fetch_state_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: fetch-unit bus to next-PC logic, consumer and instruction memory.
interface instr_fetch_unit_if;
  import fetch_pkg::*;
  logic [ADDR_W-1:0] NextPC;
  logic Stall;
  logic ImemAck;
  logic [INSTR_W-1:0] ImemData;
  logic ImemReq;
  logic [ADDR_W-1:0] ImemAddr;
  logic [ADDR_W-1:0] CurrentPC;
  logic [INSTR_W-1:0] Instruction;
  logic InstrValid;
  logic FetchFault;
  modport master (
    input NextPC, Stall, ImemAck, ImemData,
    output ImemReq, ImemAddr, CurrentPC, Instruction, InstrValid, FetchFault
  );
  modport slave (
    output NextPC, Stall, ImemAck, ImemData,
    input ImemReq, ImemAddr, CurrentPC, Instruction, InstrValid, FetchFault
  );
endinterface

// File: rtl/instr_fetch_unit_watchdog.sv
// fetch_watchdog: 8-bit ack-wait counter, expired when it reaches TIMEOUT-1.
module fetch_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic CLK,
  input  logic Reset_L,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  logic [7:0] cnt_q, cnt_d;
  assign cnt_d = clr_i ? 8'd0 : en_i ? cnt_q + 8'd1 : cnt_q;
  always_ff @(posedge CLK)
    cnt_q <= !Reset_L ? 8'd0 : cnt_d;
  assign expired_o = cnt_q == 8'(TIMEOUT - 1);
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC register and request/ack fetch sequencer with misalign and timeout faults.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0,
  parameter int TIMEOUT = 16
) (
  input logic CLK,
  input logic Reset_L,
  instr_fetch_unit_if.master bus
);
  fetch_state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic expired, misalign, take_ack, advance;
  assign misalign = |(bus.NextPC[1:0] & PC_ALIGN_MASK);
  assign take_ack = state_q == FETCH && bus.ImemAck;
  assign advance = state_q == HOLD && !bus.Stall && !misalign;
  fetch_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .CLK(CLK),
    .Reset_L(Reset_L),
    .clr_i(state_q != FETCH || bus.ImemAck),
    .en_i(state_q == FETCH),
    .expired_o(expired)
  );
  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      instr_q <= instr_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE  ? FETCH :
              state_q == FETCH ? (bus.ImemAck ? HOLD : expired ? FAULT : FETCH) :
              state_q == HOLD  ? (bus.Stall ? HOLD : misalign ? FAULT : FETCH) :
                                 FAULT;
    pc_d = advance ? bus.NextPC : pc_q;
    instr_d = take_ack ? bus.ImemData : instr_q;
  end
  always_comb begin
    bus.ImemReq = state_q == FETCH;
    bus.InstrValid = state_q == HOLD;
    bus.FetchFault = state_q == FAULT;
    bus.CurrentPC = pc_q;
    bus.ImemAddr = pc_q;
    bus.Instruction = instr_q;
  end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Program-counter register and instruction-fetch sequencer for the 64-bit single-cycle datapath. It holds CurrentPC, presents it to instruction memory through a request/acknowledge handshake, and captures the returned 32-bit instruction. It loads the next-PC value from the next-PC logic only when the downstream consumer releases the held instruction. It also flags misaligned targets and memory timeouts.

## Interface
- RESET_PC, default 64'h0: CurrentPC value loaded on reset; must be word-aligned.
- TIMEOUT, default 16: cycles spent in FETCH without ImemAck before faulting; legal range 2..255.
- CLK  in  1  clock, all state updates on rising edge.
- Reset_L  in  1  one clock; reset is synchronous and active-low.
- NextPC  in  64  next-PC value from the next-PC logic; sampled only on a HOLD-exit edge.
- Stall  in  1  consumer not ready; keeps the current instruction held.
- ImemAck  in  1  instruction memory returns ImemData this cycle.
- ImemData  in  32  instruction word; valid when ImemAck=1.
- ImemReq  out  1  fetch request; high exactly while in FETCH.
- ImemAddr  out  64  always equals CurrentPC.
- CurrentPC  out  64  PC of the instruction being fetched or held; feeds the next-PC logic.
- Instruction  out  32  captured instruction word.
- InstrValid  out  1  Instruction and CurrentPC form a valid pair.
- FetchFault  out  1  sticky fault indicator.

## Operation
- States: IDLE, FETCH, HOLD, FAULT. Registered timeout counter, 8 bits.
- Reset (Reset_L=0 at an edge), from any state:
  - state=IDLE, CurrentPC=RESET_PC, Instruction=32'h0.
  - InstrValid=0, FetchFault=0, counter=0, ImemReq=0.
- IDLE: go to FETCH unconditionally on the next edge.
- FETCH: ImemReq=1.
  - ImemAck=1: Instruction<=ImemData, InstrValid<=1, counter<=0, go to HOLD.
  - Otherwise counter++. When counter==TIMEOUT-1 with no ack, go to FAULT.
  - Stall is ignored in FETCH.
- HOLD: ImemReq=0 and InstrValid=1.
  - Stall=1: stay; all outputs stable.
  - Stall=0 and NextPC[1:0]!=2'b00: go to FAULT, InstrValid<=0, CurrentPC unchanged.
  - Stall=0 and NextPC aligned: CurrentPC<=NextPC, InstrValid<=0, go to FETCH.
- FAULT: FetchFault=1, ImemReq=0, InstrValid=0. Only reset exits this state.
- Arithmetic and widths:
  - PC is 64 bits unsigned; no increment is performed here.
  - NextPC wrap-around (e.g. 64'hFFFF_FFFF_FFFF_FFFC+4) is accepted as-is.
  - Counter compare is on the full 8 bits.

## Timing
- Minimum cost per instruction is 2 cycles: one FETCH cycle with same-cycle ack, then one HOLD cycle with Stall=0.
- Each extra ack-wait cycle or stall cycle adds one cycle.
- ImemReq, InstrValid, FetchFault and CurrentPC are registered/state-decoded and glitch-free. ImemAddr is a direct copy of the CurrentPC register.
- ImemAck is sampled only in FETCH. An ack arriving in IDLE, HOLD or FAULT is ignored.
- An ack on the same edge as reset is ignored; reset wins.
- NextPC must be stable by the HOLD-exit edge. The next-PC logic recomputes from CurrentPC, so a new CurrentPC never affects the NextPC value being sampled on the same edge.
- Timeout boundary: an ack on the edge where counter==TIMEOUT-1 is accepted, and the FSM goes to HOLD, not FAULT.

## Structure
- Shared package fetch_pkg holds:
  - fetch_state_t (IDLE, FETCH, HOLD, FAULT; 2-bit encoding).
  - ADDR_W=64 and INSTR_W=32.
  - PC_ALIGN_MASK=2'b11.
- Sub-module fetch_watchdog: the 8-bit counter with clear/enable inputs and an expired flag (counter==TIMEOUT-1). It uses the same CLK and synchronous Reset_L.
- All other logic (FSM, PC, instruction registers) stays in instr_fetch_unit.

## Test plan
- Reset, then ImemAck=1 each cycle with ImemData=32'h8B02_0020, Stall=0, NextPC=CurrentPC+4.
  - Required: CurrentPC sequence 0, 4, 8, 12, one instruction every 2 cycles.
  - Required: InstrValid pulses alternate, FetchFault=0.
- In HOLD, Stall=1 for 5 cycles with NextPC=64'h100.
  - Required: Instruction, CurrentPC and InstrValid=1 unchanged throughout.
  - Required: on the first Stall=0 edge, CurrentPC=64'h100 and ImemReq=1 on the next cycle.
- Ack withheld for TIMEOUT-1=15 cycles, then ImemAck=1 on that final edge.
  - Required: capture succeeds, no fault.
  - Rerun with the ack withheld 16 cycles: FetchFault=1 and ImemReq=0, held until reset.
- HOLD exit with NextPC=64'h102.
  - Required: FAULT, CurrentPC keeps its old value, InstrValid=0.
  - Required: reset restores CurrentPC=RESET_PC and FetchFault=0.
- Reset_L=0 mid-FETCH with ImemAck=1 on the same edge.
  - Required: Instruction=32'h0, InstrValid=0, state IDLE, then FETCH one cycle after Reset_L=1.
- NextPC=64'hFFFF_FFFF_FFFF_FFFC wraps to 64'h0.
  - Required: CurrentPC=64'h0 loaded normally, no fault.
